// File: rtl/yj_async_event_arbiter.sv
// Async level inputs -> 2-flop sync -> debounce -> per-channel pending slot,
// shared onto a single valid/ready event port by a round-robin arbiter.
module yj_aea_lane #(
    parameter int DB_CYC = 16
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic din,
    input  logic en,
    input  logic grant,
    input  logic ovf_clr,
    output logic stable,
    output logic pending,
    output logic pend_lvl,
    output logic overflow
);
    logic [1:0] sync_pipe;
    logic [7:0] cnt;
    logic       s2;
    logic       chg;

    assign s2  = sync_pipe[1];
    assign chg = (s2 != stable) && (cnt == 8'(DB_CYC - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync_pipe <= '0;
            stable    <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_pipe <= {sync_pipe[0], din};
            if (s2 == stable) begin
                cnt <= '0;
            end else if (chg) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // A change that lands on the granting cycle re-arms the slot; the grant
    // has already taken the previous level, so nothing is lost.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pending  <= 1'b0;
            pend_lvl <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (!en) begin
                pending <= 1'b0;
            end else if (chg) begin
                pending  <= 1'b1;
                pend_lvl <= s2;
            end else if (grant) begin
                pending <= 1'b0;
            end
            overflow <= (en & chg & pending & ~grant) | (overflow & ~ovf_clr);
        end
    end
endmodule

module yj_async_event_arbiter #(
    parameter  int CH     = 4,
    parameter  int DB_CYC = 16,
    localparam int CW     = (CH > 2) ? $clog2(CH) : 1
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [CH-1:0] din,
    input  logic [CH-1:0] en,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [CW-1:0] evt_ch,
    output logic          evt_level,
    output logic [CH-1:0] stable,
    output logic [CH-1:0] overflow,
    input  logic [CH-1:0] ovf_clr
);
    logic [CH-1:0] pending;
    logic [CH-1:0] pend_lvl;
    logic [CH-1:0] req;
    logic [CH-1:0] gnt;
    logic [CW-1:0] ptr;
    logic [CW-1:0] sel;
    logic [CW-1:0] cidx;
    logic          found;
    logic          load;

    for (genvar g = 0; g < CH; g++) begin : g_lane
        yj_aea_lane #(.DB_CYC(DB_CYC)) u_lane (
            .CLK      (CLK),
            .RSTn     (RSTn),
            .din      (din[g]),
            .en       (en[g]),
            .grant    (gnt[g]),
            .ovf_clr  (ovf_clr[g]),
            .stable   (stable[g]),
            .pending  (pending[g]),
            .pend_lvl (pend_lvl[g]),
            .overflow (overflow[g])
        );
    end

    // Masking with en keeps a channel being disabled this cycle from winning.
    assign req  = pending & en;
    assign load = !evt_valid || evt_ready;

    always_comb begin
        found = 1'b0;
        sel   = ptr;
        cidx  = '0;
        for (int i = 1; i <= CH; i++) begin
            cidx = CW'((int'(ptr) + i) % CH);
            if (!found && req[cidx]) begin
                found = 1'b1;
                sel   = cidx;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (load && found) gnt[sel] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_level <= 1'b0;
            ptr       <= CW'(CH - 1);
        end else if (load) begin
            evt_valid <= found;
            if (found) begin
                evt_ch    <= sel;
                evt_level <= pend_lvl[sel];
                ptr       <= sel;
            end
        end
    end
endmodule

// File: tb/tb_yj_async_event_arbiter.sv
// Bench for yj_async_event_arbiter: directed scenarios with literal
// expectations plus random traffic checked every cycle against a reference.
module tb_yj_async_event_arbiter;
    localparam int CH = 4;
    localparam int DB = 16;
    localparam int CW = 2;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic [CH-1:0] din = '0;
    logic [CH-1:0] en = '1;
    logic [CH-1:0] ovf_clr = '0;
    logic          evt_ready = 1'b1;
    logic          evt_valid;
    logic [CW-1:0] evt_ch;
    logic          evt_level;
    logic [CH-1:0] stable;
    logic [CH-1:0] overflow;

    yj_async_event_arbiter #(.CH(CH), .DB_CYC(DB)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .din       (din),
        .en        (en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_level (evt_level),
        .stable    (stable),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: pipeline of raw samples, run length of disagreement, one
    // event slot per channel, and an output slot served round-robin.
    logic [CH-1:0] m_s1, m_s2, m_stable, m_pend, m_plvl, m_ovf;
    int            m_run [CH];
    bit            m_valid;
    int            m_ch, m_lvl, m_last;

    task automatic m_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_plvl = '0; m_ovf = '0;
        for (int c = 0; c < CH; c++) m_run[c] = 0;
        m_valid = 0; m_ch = 0; m_lvl = 0; m_last = CH - 1;
    endtask

    task automatic m_step();
        bit chg [CH];
        int gnt;
        gnt = -1;
        for (int c = 0; c < CH; c++)
            chg[c] = (m_s2[c] != m_stable[c]) && (m_run[c] == DB - 1);
        if (!m_valid || evt_ready) begin
            for (int k = 1; k <= CH; k++) begin
                int c;
                c = (m_last + k) % CH;
                if (gnt < 0 && m_pend[c] && en[c]) gnt = c;
            end
            if (gnt >= 0) begin
                m_valid = 1; m_ch = gnt; m_lvl = int'(m_plvl[gnt]); m_last = gnt;
            end else begin
                m_valid = 0;
            end
        end
        for (int c = 0; c < CH; c++) begin
            bit set_ovf;
            set_ovf = 0;
            if (!en[c]) m_pend[c] = 1'b0;
            else if (chg[c]) begin
                if (m_pend[c] && gnt != c) set_ovf = 1;
                m_pend[c] = 1'b1;
                m_plvl[c] = ~m_stable[c];
            end else if (gnt == c) m_pend[c] = 1'b0;
            m_ovf[c] = set_ovf | (m_ovf[c] & ~ovf_clr[c]);
            if (chg[c]) begin
                m_stable[c] = ~m_stable[c];
                m_run[c] = 0;
            end else if (m_s2[c] != m_stable[c]) m_run[c]++;
            else m_run[c] = 0;
        end
        m_s2 = m_s1;
        m_s1 = din;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge CLK or negedge RSTn);
            if (!RSTn) m_reset();
            else m_step();
        end
    end

    initial forever begin
        @(negedge CLK);
        if (RSTn) begin
            chk("evt_valid", int'(evt_valid), int'(m_valid));
            if (m_valid) begin
                chk("evt_ch", int'(evt_ch), m_ch);
                chk("evt_level", int'(evt_level), m_lvl);
            end
            chk("stable", int'(stable), int'(m_stable));
            chk("overflow", int'(overflow), int'(m_ovf));
        end
    end

    typedef struct {int ch; int lvl; int t;} acc_t;
    acc_t acc_q[$];
    int   cyc = 0;

    initial forever begin
        @(posedge CLK);
        cyc++;
        if (RSTn && evt_valid && evt_ready)
            acc_q.push_back('{int'(evt_ch), int'(evt_level), cyc});
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        int n;
        int c1;
        cycles(3);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_stable", int'(stable), 0);
        chk("rst_ovf", int'(overflow), 0);
        RSTn = 1'b1;

        // quiet inputs
        cycles(50);
        chk("idle_valid", int'(evt_valid), 0);
        chk("idle_stable", int'(stable), 0);
        chk("idle_ovf", int'(overflow), 0);
        chk("idle_events", acc_q.size(), 0);

        // single clean edge on ch2
        acc_q.delete();
        din[2] = 1'b1;
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (!stable[2] && n < 100);
        chk("t2_latency", n, 2 + DB);
        @(posedge CLK); #1;
        chk("t2_valid", int'(evt_valid), 1);
        chk("t2_ch", int'(evt_ch), 2);
        chk("t2_lvl", int'(evt_level), 1);
        cycles(30);
        chk("t2_count", acc_q.size(), 1);

        // glitch rejection, then an accepted pulse
        acc_q.delete();
        din[1] = 1'b1; cycles(10); din[1] = 1'b0; cycles(40);
        chk("glitch_stable", int'(stable[1]), 0);
        chk("glitch_events", acc_q.size(), 0);
        din[1] = 1'b1; cycles(20); din[1] = 1'b0; cycles(60);
        chk("pulse_count", acc_q.size(), 2);
        chk("pulse0_ch", acc_q[0].ch, 1);
        chk("pulse0_lvl", acc_q[0].lvl, 1);
        chk("pulse1_ch", acc_q[1].ch, 1);
        chk("pulse1_lvl", acc_q[1].lvl, 0);

        // all channels at once after a fresh reset
        din = '0; RSTn = 1'b0; cycles(1); RSTn = 1'b1; cycles(5);
        acc_q.delete();
        din = '1; cycles(30);
        chk("burst_count", acc_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("burst_ch", acc_q[k].ch, k);
            chk("burst_gap", acc_q[k].t - acc_q[0].t, k);
        end

        // backpressure with repeated ch0 changes
        din = '0; cycles(30);
        evt_ready = 1'b0; acc_q.delete();
        din[0] = 1'b1; cycles(25); din[0] = 1'b0; cycles(25);
        din[0] = 1'b1; cycles(25); din[0] = 1'b0; cycles(25);
        chk("bp_valid", int'(evt_valid), 1);
        chk("bp_ch", int'(evt_ch), 0);
        chk("bp_lvl", int'(evt_level), 1);
        chk("bp_ovf", int'(overflow[0]), 1);
        evt_ready = 1'b1; cycles(1); evt_ready = 1'b0;
        chk("bp_next_ch", int'(evt_ch), 0);
        chk("bp_next_lvl", int'(evt_level), 0);
        ovf_clr[0] = 1'b1; cycles(1); ovf_clr[0] = 1'b0;
        chk("ovf_cleared", int'(overflow[0]), 0);
        din[0] = 1'b1; cycles(25);
        chk("ovf_no_set", int'(overflow[0]), 0);
        din[0] = 1'b0; cycles(DB + 1);
        ovf_clr[0] = 1'b1; cycles(1); ovf_clr[0] = 1'b0;
        chk("ovf_set_wins", int'(overflow[0]), 1);

        // disabled channel still debounces but raises nothing
        evt_ready = 1'b1; cycles(10); acc_q.delete();
        en[1] = 1'b0; din[1] = 1'b1; cycles(30);
        chk("en_stable", int'(stable[1]), 1);
        c1 = 0;
        foreach (acc_q[i]) if (acc_q[i].ch == 1) c1++;
        chk("en_events", c1, 0);
        en[1] = 1'b1;

        // reset during a held event
        evt_ready = 1'b0; din[3] = 1'b1; cycles(25);
        chk("hold_valid", int'(evt_valid), 1);
        #2 RSTn = 1'b0;
        #1;
        chk("arst_valid", int'(evt_valid), 0);
        chk("arst_ch", int'(evt_ch), 0);
        chk("arst_lvl", int'(evt_level), 0);
        chk("arst_stable", int'(stable), 0);
        chk("arst_ovf", int'(overflow), 0);
        cycles(1);
        din = 4'b1001; RSTn = 1'b1; evt_ready = 1'b1; acc_q.delete();
        cycles(30);
        chk("prio_count", acc_q.size(), 2);
        chk("prio_first", acc_q[0].ch, 0);
        chk("prio_second", acc_q[1].ch, 3);

        // random traffic
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(29) == 0) din[c] = ~din[c];
            evt_ready = ($urandom_range(3) != 0);
            if ($urandom_range(199) == 0) en[$urandom_range(CH - 1)] ^= 1'b1;
            ovf_clr = ($urandom_range(15) == 0) ? CH'($urandom) : '0;
            cycles(1);
        end
        en = '1; ovf_clr = '0; evt_ready = 1'b1;
        cycles(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
